// File: rtl/fir_pkg.sv
// Shared constants and helpers for the fixed-coefficient 15-tap FIR filter.
package fir_pkg;

  localparam int NTAPS = 15;

  // Headroom added above the coefficient and sample integer bits so that the
  // 15-term sum can never wrap.
  localparam int ACC_GUARD_WL = 4;

  typedef int tap_int_t [0:NTAPS-1];

  // Symmetric low-pass taps, raw integers in coefficient format (sum = 256 = 1.0).
  localparam tap_int_t COE_DEFAULT =
    '{-2, 0, 6, 0, -18, 0, 78, 128, 78, 0, -18, 0, 6, 0, -2};

  // Fractional bits kept for each per-tap product.
  localparam tap_int_t PROD_WL_DEFAULT = '{default: 12};

  // Widest product fraction; every product is aligned to this before summing.
  function automatic int max_wl(tap_int_t wl);
    int m;
    m = 0;
    for (int k = 0; k < NTAPS; k++) begin
      if (wl[k] > m) m = wl[k];
    end
    return m;
  endfunction

  // Accumulator width: coefficient + sample integer bits, guard bits, F fraction bits.
  function automatic int acc_width(int coe_inte_wl, int in_inte_wl, int frac_wl);
    return coe_inte_wl + in_inte_wl + ACC_GUARD_WL + frac_wl;
  endfunction

endpackage

// File: rtl/fir_tap_mult.sv
// One FIR tap: constant-coefficient signed multiply, floored to a chosen fraction.
module fir_tap_mult #(
  parameter int COE_W   = 12,
  parameter int IN_W    = 12,
  parameter int DROP_W  = 4,
  parameter int COE_VAL = 0
) (
  input  logic signed [IN_W-1:0]              x,
  output logic signed [COE_W+IN_W-DROP_W-1:0] p
);

  localparam int FULL_W = COE_W + IN_W;
  localparam int PROD_W = FULL_W - DROP_W;
  localparam logic signed [COE_W-1:0] COEF = COE_VAL[COE_W-1:0];

  logic signed [FULL_W-1:0] full;

  // Full-precision product; arithmetic right shift drops LSBs, i.e. floors.
  always_comb begin
    full = COEF * x;
    p    = PROD_W'(full >>> DROP_W);
  end

endmodule

// File: rtl/fir_filter.sv
// 15-tap direct-form FIR: delay line, per-tap quantised products, summed,
// floored and saturated to the output format. Two-cycle latency.
module fir_filter
  import fir_pkg::*;
#(
  parameter int       COE_INTE_WL           = 4,
  parameter int       COE_FRAC_WL           = 8,
  parameter int       IN_INTE_WL            = 4,
  parameter int       IN_FRAC_WL            = 8,
  parameter int       OUT_INTE_WL           = 4,
  parameter int       OUT_FRAC_WL           = 8,
  parameter tap_int_t PRODUCT_FRAC_WL_ARRAY = PROD_WL_DEFAULT,
  parameter tap_int_t COE                   = COE_DEFAULT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic signed [IN_INTE_WL+IN_FRAC_WL-1:0]   data_in,
  input  logic                                      in_valid,
  output logic signed [OUT_INTE_WL+OUT_FRAC_WL-1:0] data_out,
  output logic                                      out_valid
);

  localparam int COE_W     = COE_INTE_WL + COE_FRAC_WL;
  localparam int IN_W      = IN_INTE_WL + IN_FRAC_WL;
  localparam int OUT_W     = OUT_INTE_WL + OUT_FRAC_WL;
  localparam int FULL_FRAC = COE_FRAC_WL + IN_FRAC_WL;
  localparam int F         = max_wl(PRODUCT_FRAC_WL_ARRAY);
  localparam int ACC_W     = acc_width(COE_INTE_WL, IN_INTE_WL, F);
  localparam int DN        = (F > OUT_FRAC_WL) ? F - OUT_FRAC_WL : 0;
  localparam int UP        = (OUT_FRAC_WL > F) ? OUT_FRAC_WL - F : 0;
  localparam int Q_W       = ACC_W - DN + UP;

  localparam logic signed [Q_W-1:0] SAT_MAX = Q_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [Q_W-1:0] SAT_MIN = Q_W'(-(2 ** (OUT_W - 1)));

  logic signed [IN_W-1:0]  x_p1 [0:NTAPS-1];
  logic                    vld_p1;
  logic signed [ACC_W-1:0] term [0:NTAPS-1];
  logic signed [ACC_W-1:0] acc;
  logic signed [OUT_W-1:0] data_p2;
  logic                    vld_p2;

  // Floor the accumulator to the output fraction (zero-extend if output is finer).
  function automatic logic signed [Q_W-1:0] floor_out(input logic signed [ACC_W-1:0] a);
    return Q_W'(a >>> DN) <<< UP;
  endfunction

  // Clip to the representable output range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [Q_W-1:0] q);
    if (q > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (q < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                  return q[OUT_W-1:0];
  endfunction

  // Stage 1: delay line advances only on accepted samples; valid follows every edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NTAPS; k++) x_p1[k] <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        x_p1[0] <= data_in;
        for (int k = 1; k < NTAPS; k++) x_p1[k] <= x_p1[k-1];
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    localparam int PWK    = PRODUCT_FRAC_WL_ARRAY[k];
    localparam int PROD_W = COE_W + IN_W - (FULL_FRAC - PWK);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  ext;

    fir_tap_mult #(
      .COE_W  (COE_W),
      .IN_W   (IN_W),
      .DROP_W (FULL_FRAC - PWK),
      .COE_VAL(COE[k])
    ) u_mult (
      .x(x_p1[k]),
      .p(prod)
    );

    // Sign-extend and align the product's fraction to F.
    always_comb begin
      ext     = ACC_W'(prod);
      term[k] = ext <<< (F - PWK);
    end
  end

  // Sum of all aligned products; width is chosen so this cannot overflow.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NTAPS; k++) acc = acc + term[k];
  end

  // Stage 2: quantised output register; updates every edge, qualified by vld_p2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      data_p2 <= saturate(floor_out(acc));
      vld_p2  <= vld_p1;
    end
  end

  assign data_out  = data_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_fir_filter.sv
// Directed bench for fir_filter: reset, impulse, step, saturation, valid gaps,
// mid-stream reset and per-product word length.
module tb_fir_filter;
  import fir_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [11:0] data_in;
  logic               in_valid;
  logic signed [11:0] data_out, data_out4;
  logic               out_valid, out_valid4;

  int checks   = 0;
  int failures = 0;

  localparam tap_int_t WL4 = '{default: 4};

  int imp_exp [0:14] = '{-2, 0, 6, 0, -18, 0, 78, 128, 78, 0, -18, 0, 6, 0, -2};

  fir_filter dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .data_out(data_out), .out_valid(out_valid)
  );

  fir_filter #(.PRODUCT_FRAC_WL_ARRAY(WL4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .data_out(data_out4), .out_valid(out_valid4)
  );

  always #5 clk = ~clk;

  // Drive one cycle from a negedge; outputs are sampled at the following negedge.
  task automatic step(input logic v, input logic signed [11:0] d);
    in_valid = v;
    data_in  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(1'b0, 12'sd0);
    step(1'b0, 12'sd0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1'($urandom), 12'($urandom));
      checks++;
      if (data_out !== 12'sd0) begin
        failures++;
        $display("FAIL reset_data[%0d]: got %0d expected 0", i, data_out);
      end
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_valid[%0d]: got %b expected 0", i, out_valid);
      end
    end
    rst = 1'b1;
    step(1'b1, 12'sd256);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_valid_early: got %b expected 0", out_valid);
    end
    step(1'b0, 12'sd0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== -12'sd2) begin
      failures++;
      $display("FAIL first_output: got v=%b d=%0d expected v=1 d=-2", out_valid, data_out);
    end
    step(1'b0, 12'sd0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_valid_width: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_impulse();
    int e;
    do_reset();
    for (int i = 0; i <= 21; i++) begin
      step(i < 21, (i == 0) ? 12'sd256 : 12'sd0);
      if (i >= 1) begin
        e = (i - 1 < 15) ? imp_exp[i-1] : 0;
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'(e)) begin
          failures++;
          $display("FAIL impulse[%0d]: got v=%b d=%0d expected v=1 d=%0d", i - 1, out_valid, data_out, e);
        end
      end
    end
  endtask

  task automatic test_step();
    int ramp [0:15] = '{-2, -2, 4, 4, -14, -14, 64, 192, 270, 270, 252, 252, 258, 258, 256, 256};
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step(i < 16, 12'sd256);
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'(ramp[i-1])) begin
          failures++;
          $display("FAIL step256[%0d]: got v=%b d=%0d expected v=1 d=%0d", i - 1, out_valid, data_out, ramp[i-1]);
        end
      end
    end
    // Full-scale constant: products floored to 12 fraction bits sum to 32750/4096,
    // which floors to 2046/256.
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      step(i < 16, 12'sd2047);
      if (i >= 15) begin
        checks++;
        if (out_valid !== 1'b1 || data_out !== 12'sd2046) begin
          failures++;
          $display("FAIL step2047[%0d]: got v=%b d=%0d expected v=1 d=2046", i - 1, out_valid, data_out);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [11:0] pat [0:14];
    pat = '{-12'sd2048, 12'sd0, 12'sd2047, 12'sd0, -12'sd2048, 12'sd0, 12'sd2047, 12'sd2047,
            12'sd2047, 12'sd0, -12'sd2048, 12'sd0, 12'sd2047, 12'sd0, -12'sd2048};
    do_reset();
    for (int i = 0; i < 15; i++) step(1'b1, pat[i]);
    step(1'b0, 12'sd0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 12'sd2047) begin
      failures++;
      $display("FAIL sat_pos: got v=%b d=%0d expected v=1 d=2047", out_valid, data_out);
    end
    do_reset();
    for (int i = 0; i < 15; i++)
      step(1'b1, (pat[i] == 12'sd2047) ? -12'sd2048 : (pat[i] == -12'sd2048) ? 12'sd2047 : 12'sd0);
    step(1'b0, 12'sd0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== -12'sd2048) begin
      failures++;
      $display("FAIL sat_neg: got v=%b d=%0d expected v=1 d=-2048", out_valid, data_out);
    end
  endtask

  task automatic test_valid_gaps();
    logic prev_v;
    int   n;
    int   e;
    do_reset();
    prev_v = 1'b0;
    n = 0;
    for (int i = 0; i < 44; i++) begin
      // Even steps carry samples (impulse then zeros); odd steps are gaps with junk data.
      step((i % 2 == 0) && (i < 42), (i % 2 == 1) ? 12'sh5A5 : (i == 0) ? 12'sd256 : 12'sd0);
      checks++;
      if (out_valid !== prev_v) begin
        failures++;
        $display("FAIL gap_valid[%0d]: got %b expected %b", i, out_valid, prev_v);
      end
      if (prev_v) begin
        e = (n < 15) ? imp_exp[n] : 0;
        checks++;
        if (data_out !== 12'(e)) begin
          failures++;
          $display("FAIL gap_data[%0d]: got %0d expected %0d", n, data_out, e);
        end
        n++;
      end
      prev_v = (i % 2 == 0) && (i < 42);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    step(1'b1, 12'sd256);
    for (int i = 0; i < 8; i++) step(1'b1, 12'sd0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (data_out !== 12'sd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got v=%b d=%0d expected v=0 d=0", out_valid, data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 12'sd0);
    step(1'b1, 12'sd0);
    checks++;
    if (out_valid !== 1'b1 || data_out !== 12'sd0) begin
      failures++;
      $display("FAIL post_reset_history: got v=%b d=%0d expected v=1 d=0", out_valid, data_out);
    end
  endtask

  task automatic test_product_wl();
    int s4;
    int dflt [0:14] = '{-1, -1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    s4 = 0;
    for (int i = 0; i <= 15; i++) begin
      step(i < 15, 12'sd1);
      if (i >= 1) begin
        // Raw 1 times COE[k] has 16 fraction bits; floor to 4, realign to 8.
        s4 = s4 + (imp_exp[i-1] >>> 12);
        checks++;
        if (out_valid4 !== 1'b1 || data_out4 !== 12'(s4 * 16)) begin
          failures++;
          $display("FAIL pwl4[%0d]: got v=%b d=%0d expected v=1 d=%0d", i - 1, out_valid4, data_out4, s4 * 16);
        end
        checks++;
        if (data_out !== 12'(dflt[i-1])) begin
          failures++;
          $display("FAIL pwl12[%0d]: got %0d expected %0d", i - 1, data_out, dflt[i-1]);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_step();
    test_saturation();
    test_valid_gaps();
    test_midreset();
    test_product_wl();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
